// File: rtl/display_pkg.sv
// Command codes and arbiter state type shared by display, display_spi
// and display_spi_arbiter.
package display_pkg;

  localparam logic [2:0] CMD_NONE         = 3'd0;
  localparam logic [2:0] CMD_RESET        = 3'd1;
  localparam logic [2:0] CMD_SEND_COMMAND = 3'd2;
  localparam logic [2:0] CMD_SEND_DATA    = 3'd3;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_HOLDOFF = 2'd2
  } arb_state_e;

endpackage

// File: rtl/display_arb_pick.sv
// Combinational two-way round-robin picker; a held lock masks out the
// non-owner so only the owner can win.
module display_arb_pick
  import display_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  input  logic       locked_i,
  input  logic       owner_i,
  output logic       grant_valid_o,
  output logic       grant_idx_o
);

  logic [1:0] eligible;

  always_comb begin
    eligible = valid_i;
    if (locked_i) begin
      eligible = owner_i ? (valid_i & 2'b10) : (valid_i & 2'b01);
    end
    grant_valid_o = |eligible;
    // On a tie the port that did not win last time goes next.
    grant_idx_o   = eligible[1] & (~eligible[0] | ~last_grant_i);
  end

endmodule

// File: rtl/display_spi_arbiter.sv
// Round-robin arbiter with lock sharing the display_spi command port.
// Optional lock watchdog: define DSPI_ARB_LOCK_TIMEOUT_EN.
module display_spi_arbiter
  import display_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] p0_cmd,
  input  logic [7:0] p0_byte,
  input  logic       p0_lock,
  input  logic [2:0] p1_cmd,
  input  logic [7:0] p1_byte,
  input  logic       p1_lock,
  output logic       p0_ack,
  output logic       p1_ack,
  output logic [2:0] dspi_cmd,
  output logic [7:0] dspi_byte,
  input  logic       dspi_ready,
  output logic       busy,
  output logic       lock_timeout
);

  arb_state_e state_q, state_d;
  logic [2:0] cmd_q, cmd_d;
  logic [7:0] byte_q, byte_d;
  logic [1:0] ack_q, ack_d;
  logic       locked_q, locked_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;

  logic [1:0] valid;
  logic       grant_valid;
  logic       grant_idx;
  logic [2:0] win_cmd;
  logic [7:0] win_byte;
  logic       win_lock;
  logic [2:0] own_cmd;
  logic       own_lock;

  assign valid    = {p1_cmd != CMD_NONE, p0_cmd != CMD_NONE};
  assign win_cmd  = grant_idx ? p1_cmd  : p0_cmd;
  assign win_byte = grant_idx ? p1_byte : p0_byte;
  assign win_lock = grant_idx ? p1_lock : p0_lock;
  assign own_cmd  = owner_q ? p1_cmd  : p0_cmd;
  assign own_lock = owner_q ? p1_lock : p0_lock;

  display_arb_pick u_pick (
    .valid_i      (valid),
    .last_grant_i (last_q),
    .locked_i     (locked_q),
    .owner_i      (owner_q),
    .grant_valid_o(grant_valid),
    .grant_idx_o  (grant_idx)
  );

`ifdef DSPI_ARB_LOCK_TIMEOUT_EN
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(LOCK_TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic             lock_idle;
  logic             force_release;
`endif

  always_comb begin
    state_d  = state_q;
    cmd_d    = CMD_NONE;
    byte_d   = byte_q;
    ack_d    = 2'b00;
    locked_d = locked_q;
    owner_d  = owner_q;
    last_d   = last_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (dspi_ready && grant_valid) begin
          cmd_d            = win_cmd;
          byte_d           = win_byte;
          ack_d[grant_idx] = 1'b1;
          last_d           = grant_idx;
          locked_d         = win_lock;
          owner_d          = win_lock ? grant_idx : owner_q;
          state_d          = ARB_ISSUE;
        end else if (locked_q && own_cmd == CMD_NONE && !own_lock) begin
          locked_d = 1'b0;
        end
      end
      ARB_ISSUE:   state_d = ARB_HOLDOFF;
      ARB_HOLDOFF: state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
`ifdef DSPI_ARB_LOCK_TIMEOUT_EN
    // Owner parked on its lock without asking for anything: count toward release.
    lock_idle     = (state_q == ARB_IDLE) && locked_q && own_cmd == CMD_NONE && own_lock;
    force_release = lock_idle && (cnt_q + 1'b1 == TMO);
    tmo_d         = tmo_q | force_release;
    cnt_d         = '0;
    if (force_release) begin
      locked_d = 1'b0;
    end else if (lock_idle) begin
      cnt_d = cnt_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      cmd_q    <= CMD_NONE;
      byte_q   <= 8'h00;
      ack_q    <= 2'b00;
      locked_q <= 1'b0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      byte_q   <= byte_d;
      ack_q    <= ack_d;
      locked_q <= locked_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
    end
  end

`ifdef DSPI_ARB_LOCK_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign lock_timeout = tmo_q;
`else
  assign lock_timeout = 1'b0;
`endif

  assign dspi_cmd  = cmd_q;
  assign dspi_byte = byte_q;
  assign p0_ack    = ack_q[0];
  assign p1_ack    = ack_q[1];
  assign busy      = (state_q != ARB_IDLE) || locked_q;

endmodule

// File: doc/display_spi_arbiter.md
# display_spi_arbiter

Shares the single `display_spi` command port between two requesters: port 0 is the `display` refresh sequencer and port 1 is an auxiliary command source, such as contrast, invert or scroll updates. The block sits between the requesters and `display_spi`. It issues one-cycle command pulses only when `display_spi` is idle, and arbitrates round-robin. A lock keeps multi-byte SSD1306 command sequences, such as COLUMNADDR plus its two arguments, from being interleaved with the other port's traffic.

## Interface
Parameters:
- `LOCK_TIMEOUT`, default 4096: number of idle cycles a lock may be held without a request before it is force-released (used only with the macro).

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `p0_cmd`, `p1_cmd`  in  3  requested command: NONE=0, RESET=1, SEND_COMMAND=2, SEND_DATA=3. Non-NONE means the request is valid.
- `p0_byte`, `p1_byte`  in  8  command/data byte.
- `p0_lock`, `p1_lock`  in  1  keep the grant after this transfer.
- `p0_ack`, `p1_ack`  out  1  one-cycle pulse: this port's request was issued.
- `dspi_cmd`  out  3  command to `display_spi`.
- `dspi_byte`  out  8  byte to `display_spi`.
- `dspi_ready`  in  1  `display_spi` is idle. It is valid only while `dspi_cmd`=NONE.
- `busy`  out  1  state is not IDLE, or a lock is held.
- `lock_timeout`  out  1  sticky flag: a lock was force-released.

## Operation
- **States:** IDLE, ISSUE, HOLDOFF.
- **IDLE:**
  - The arbiter drives `dspi_cmd`=NONE.
  - If `dspi_ready`=1 and an eligible port has a valid request, the winner's cmd and byte are registered onto `dspi_cmd`/`dspi_byte`, and the next state is ISSUE.
  - Requests are sampled only in this cycle. A request withdrawn earlier is simply not seen.
- **ISSUE (exactly 1 cycle):**
  - `dspi_cmd`/`dspi_byte` carry the captured values.
  - The winner's `pN_ack`=1.
  - `last_grant` is set to the winner.
  - If the winner's lock (sampled at arbitration) is 1: `locked`=1 and `owner`=winner. Otherwise `locked`=0.
  - The next state is HOLDOFF.
- **HOLDOFF (1 cycle):** `dspi_cmd`=NONE and `dspi_ready` is ignored. Next state is IDLE.
- **Eligibility:**
  - If `locked`=1, only `owner` is eligible.
  - Otherwise, if both ports request, the port that is not `last_grant` wins. If one port requests, it wins.
- **Lock release:**
  - The owner's next transfer with lock=0 releases the lock.
  - In IDLE, the owner having cmd=NONE and lock=0 clears `locked` on that edge.
- **RESET command:** CMD_RESET is passed through like any other command. The lock rules apply unchanged.
- **Requester rule:** a requester holds cmd, byte and lock stable until its ack. After the ack it may present the next request in the same cycle the ack is seen.

## Timing
- **Reset values:**
  - `dspi_cmd`=NONE, `dspi_byte`=0, `p0_ack`=`p1_ack`=0, `busy`=0, `lock_timeout`=0.
  - Internal: state=IDLE, `locked`=0, `owner`=0, `last_grant`=1, so port 0 wins the first tie.
- **Latency:** request valid and `dspi_ready`=1 at cycle t → `dspi_cmd` and ack at t+1 → NONE at t+2.
- **Throughput:** the earliest next issue is at t+4, and in practice it is gated by `dspi_ready`.
- **Ack alignment:** the ack is coincident with the `dspi_cmd` pulse. The two never appear without each other.
- **Simultaneous requests with no lock:** ports strictly alternate.
- **Lock starvation:** while a port holds a lock, the other port waits indefinitely unless the macro is enabled.
- **Reset mid-operation:** `rst` during ISSUE or HOLDOFF returns all outputs to reset values on the next edge. No ack is generated after reset. A byte already being shifted by `display_spi` is finished by that block. The arbiter then waits for `dspi_ready` in IDLE.

## Configuration
- **Macro `DSPI_ARB_LOCK_TIMEOUT_EN`:**
  - **Defined:**
    - A counter of width $clog2(`LOCK_TIMEOUT`+1) increments in each IDLE cycle with `locked`=1 and the owner not requesting.
    - The counter clears on any issue or lock release.
    - On reaching `LOCK_TIMEOUT`, `locked` is cleared and `lock_timeout` is set; it stays set until `rst`.
  - **Undefined:** there is no counter, locks are held indefinitely, and `lock_timeout` is tied to 0.

## Structure
- **Shared package `display_pkg`:**
  - Command codes CMD_NONE, CMD_RESET, CMD_SEND_COMMAND and CMD_SEND_DATA, replacing the file-local macros so `display`, `display_spi` and this block share them.
  - The arbiter state enum.
- **Sub-module `display_arb_pick`:** combinational two-way round-robin picker with lock masking. Inputs are valid[1:0], `last_grant`, `locked` and `owner`. Outputs are grant_valid and grant_idx.

## Test plan
- **Single request:** port 0 sends SEND_COMMAND 0xAE with `dspi_ready`=1 → `dspi_cmd`=2, `dspi_byte`=0xAE and `p0_ack` for exactly 1 cycle, then NONE.
- **Round-robin:** both ports request continuously, unlocked, behind a `display_spi` model → grant order 0,1,0,1 and no ack for a port while the other is issuing.
- **Lock:** port 1 sends 0x21, 0x00, 0x7F with lock=1,1,0 while port 0 requests → port 1's three bytes are contiguous and port 0 is issued next.
- **Timeout:** with macro defined and `LOCK_TIMEOUT`=8, port 0 locks then goes idle → after 8 idle cycles port 1 is granted and `lock_timeout`=1. Repeat without the macro → port 1 is never granted and `lock_timeout`=0.
- **Reset mid-operation:** assert `rst` during ISSUE → next cycle `dspi_cmd`=NONE, both acks 0, `busy`=0, and port 0 wins the first subsequent tie.
